// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a common-anode 7-segment bank
//
// Holds a BCD value, decimal-point flag and blink flag per digit. It walks the digits
// with an all-anodes-off gap between them to stop ghosting, decodes the selected digit
// onto the shared seg/dp bus, and gates blinking digits with one shared blink phase.
// All pin outputs are registered, so the pins lag internal state and slot writes by
// one clock.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous reset, active-low
//   wr_en_i       single-cycle write strobe for a digit slot
//   wr_addr_i     digit index to write; indexes >= NUM_DIGITS are ignored
//   wr_data_i     BCD value; 10..15 blank the digit
//   wr_dp_i       decimal point on for this digit
//   wr_blink_i    digit takes part in blinking
//   blink_rate_i  blink half-period in clk cycles; 0 disables blinking
//   seg_o         segments, active-low, seg_o[6]=A .. seg_o[0]=G
//   dp_o          decimal point, active-low
//   an_o          digit anodes, active-low, at most one low
//   digit_idx_o   index of the digit currently being scanned
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wr_en_i,
   input  logic [2:0]            wr_addr_i,
   input  logic [3:0]            wr_data_i,
   input  logic                  wr_dp_i,
   input  logic                  wr_blink_i,
   input  logic [23:0]           blink_rate_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic [2:0]            digit_idx_o
);
   localparam int AW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC);
   // Lit-segment patterns A..G; 10..15 are all off.
   localparam logic [6:0] LIT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                                       7'h70, 7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00,
                                       7'h00, 7'h00};

   typedef enum logic {BLANK, SHOW} state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [AW-1:0]         idx_q;
   logic [3:0]            val_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] sdp_q, sbl_q;
   logic [23:0]           bcnt_q;
   logic                  bph_q;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  last, dark;
   logic [AW-1:0]         wa;

   assign wa = wr_addr_i[AW-1:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_DIGITS; i++) val_q[i] <= 4'hF;
         sdp_q <= '0;
         sbl_q <= '0;
      end else if (wr_en_i && 32'(wr_addr_i) < NUM_DIGITS) begin
         val_q[wa] <= wr_data_i;
         sdp_q[wa] <= wr_dp_i;
         sbl_q[wa] <= wr_blink_i;
      end
   end

   // >= rather than == so a rate lowered below the running count wraps next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bcnt_q <= '0;
         bph_q  <= 1'b1;
      end else if (blink_rate_i == '0) begin
         bcnt_q <= '0;
         bph_q  <= 1'b1;
      end else if (bcnt_q >= blink_rate_i - 24'd1) begin
         bcnt_q <= '0;
         bph_q  <= ~bph_q;
      end else begin
         bcnt_q <= bcnt_q + 24'd1;
      end
   end

   // Pin values derived from the current state; registered below for glitch-free pins.
   always_comb begin
      last  = cnt_q == (state_q == SHOW ? CW'(SCAN_DIV - 1) : CW'(BLANK_CYC - 1));
      dark  = state_q == BLANK || (sbl_q[idx_q] && !bph_q);
      an_d  = state_q == SHOW ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg_d = dark ? 7'h7F : ~LIT[val_q[idx_q]];
      dp_d  = dark ? 1'b1 : ~sdp_q[idx_q];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= '1;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
         cnt_q <= last ? '0 : cnt_q + 1'b1;
         if (last) state_q <= state_q == SHOW ? BLANK : SHOW;
         if (last && state_q == SHOW) idx_q <= idx_q == AW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      end
   end

   assign seg_o       = seg_q;
   assign dp_o        = dp_q;
   assign an_o        = an_q;
   assign digit_idx_o = 3'(idx_q);
endmodule
